// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: FSM encoding,
// Gray-code phase values, direction values and the up-sequence successor helper.
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Successor of a phase along the up sequence 00->10->11->01->00.
  // A down step is simply the reverse, so one table serves both directions.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nx;
    nx = PH_00;
    case (ph)
      PH_00:   nx = PH_10;
      PH_10:   nx = PH_11;
      PH_11:   nx = PH_01;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Single-bit N-flop synchroniser for an asynchronous input; async active-low reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/quad_decoder_updown.sv
// Quadrature A/B decoder: resynchronises the phases, decodes Gray-code steps
// into a wrapping up/down position count and flags double-bit (illegal) jumps.
module quad_decoder_updown
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             up,
  output logic             step,
  output logic             err
);

  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

  logic a_s, b_s;
  logic [1:0] p;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i (clock), .rst_ni(reset), .d_i(qa), .q_o(a_s)
  );
  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i (clock), .rst_ni(reset), .d_i(qb), .q_o(b_s)
  );

  assign p = {a_s, b_s};

  state_e           state_q, state_d;
  logic [IW-1:0]    init_q,  init_d;
  logic [1:0]       prev_q,  prev_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             up_q,    up_d;
  logic             step_q,  step_d;
  logic             err_q,   err_d;

  logic is_up, is_dn, is_bad;

  assign is_up  = (p == next_up(prev_q));
  assign is_dn  = (prev_q == next_up(p));
  assign is_bad = ((prev_q ^ p) == 2'b11);

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    step_d  = 1'b0;
    err_d   = err_q;

    // Clear first so a same-cycle illegal jump below overrides it.
    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Wait for the synchronisers to fill, then adopt the phase as baseline
        // so whatever level is present at reset release never counts as a step.
        if (init_q == INIT_LAST) begin
          prev_d  = p;
          state_d = ST_TRACK;
        end else begin
          init_d = init_q + 1'b1;
        end
      end
      default: begin
        prev_d = p;
        if (is_up) begin
          step_d = 1'b1;
          up_d   = DIR_UP;
          cnt_d  = cnt_q + 1'b1;
        end else if (is_dn) begin
          step_d = 1'b1;
          up_d   = DIR_DN;
          cnt_d  = cnt_q - 1'b1;
        end else if (is_bad) begin
          err_d = 1'b1;
        end
      end
    endcase

    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      prev_q  <= PH_00;
      cnt_q   <= '0;
      up_q    <= DIR_UP;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign up   = up_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder_updown.sv
// Scoreboard bench for quad_decoder_updown: stimulus pushes expected {up,cnt}
// per valid step; a negedge monitor pops and compares on every step pulse.
module tb_quad_decoder_updown;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             qa = 1'b0, qb = 1'b0;
  logic             clr = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] cnt;
  logic             up, step, err;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH:0] exp_q[$];

  quad_decoder_updown #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .qa(qa), .qb(qb), .clr(clr),
    .err_clr(err_clr), .cnt(cnt), .up(up), .step(step), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic phase(input logic [1:0] ph);
    {qa, qb} = ph;
    tick(4);
  endtask

  // Expected step: push {up, cnt} then drive the phase.
  task automatic stepph(input logic [1:0] ph, input logic dir, input int c);
    exp_q.push_back({dir, 4'(c)});
    phase(ph);
  endtask

  always @(negedge clock) begin
    if (reset && step) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step_cnt", int'(cnt), -1);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("step_cnt", int'(cnt), int'(e[WIDTH-1:0]));
        chk("step_up", int'(up), int'(e[WIDTH]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with phases at 11: INIT must swallow them silently.
    {qa, qb} = 2'b11;
    tick(3);
    reset = 1'b1;
    tick(8);
    chk("init_cnt", int'(cnt), 0);
    chk("init_err", int'(err), 0);
    chk("init_up", int'(up), 1);
    chk("init_step", int'(step), 0);

    // Re-baseline at phase 00.
    reset = 1'b0;
    {qa, qb} = 2'b00;
    tick(2);
    reset = 1'b1;
    tick(6);

    // Four full up cycles: 1..15 then wrap to 0.
    for (int r = 0; r < 4; r++) begin
      stepph(2'b10, 1'b1, (4*r+1) % 16);
      stepph(2'b11, 1'b1, (4*r+2) % 16);
      stepph(2'b01, 1'b1, (4*r+3) % 16);
      stepph(2'b00, 1'b1, (4*r+4) % 16);
    end
    chk("up_wrap_cnt", int'(cnt), 0);

    // Down from 0 wraps to 15.
    stepph(2'b01, 1'b0, 15);
    stepph(2'b11, 1'b0, 14);
    stepph(2'b10, 1'b0, 13);
    chk("down_cnt", int'(cnt), 13);
    chk("down_up", int'(up), 0);
    stepph(2'b00, 1'b0, 12);
    stepph(2'b01, 1'b0, 11);

    // Clear with no step in flight, then climb to 5 landing on phase 00.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    chk("clr_cnt", int'(cnt), 0);
    stepph(2'b00, 1'b1, 1);
    stepph(2'b10, 1'b1, 2);
    stepph(2'b11, 1'b1, 3);
    stepph(2'b01, 1'b1, 4);
    stepph(2'b00, 1'b1, 5);

    // Illegal 00->11.
    phase(2'b11);
    chk("illegal_err", int'(err), 1);
    chk("illegal_cnt", int'(cnt), 5);
    chk("illegal_up", int'(up), 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("errclr_err", int'(err), 0);

    // err_clr coincident with illegal 11->00 decode: error must win.
    {qa, qb} = 2'b00;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2);
    chk("errclr_vs_illegal_err", int'(err), 1);
    chk("errclr_vs_illegal_cnt", int'(cnt), 5);

    // clr coincident with decoded up step 11->01 at cnt 7.
    stepph(2'b10, 1'b1, 6);
    stepph(2'b11, 1'b1, 7);
    exp_q.push_back({1'b1, 4'd0});
    {qa, qb} = 2'b01;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(2);
    chk("clr_prio_cnt", int'(cnt), 0);

    // Climb to 9, then an asynchronous reset pulse.
    stepph(2'b00, 1'b1, 1);
    stepph(2'b10, 1'b1, 2);
    stepph(2'b11, 1'b1, 3);
    stepph(2'b01, 1'b1, 4);
    stepph(2'b00, 1'b1, 5);
    stepph(2'b10, 1'b1, 6);
    stepph(2'b11, 1'b1, 7);
    stepph(2'b01, 1'b1, 8);
    stepph(2'b00, 1'b1, 9);
    chk("pre_reset_cnt", int'(cnt), 9);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_cnt", int'(cnt), 0);
    chk("async_reset_err", int'(err), 0);
    #2 reset = 1'b1;
    tick(6);
    chk("post_reset_cnt", int'(cnt), 0);
    stepph(2'b10, 1'b1, 1);
    stepph(2'b11, 1'b1, 2);
    stepph(2'b01, 1'b1, 3);
    chk("post_reset_final_cnt", int'(cnt), 3);

    tick(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
